issue_execute: RTL and testbench

ISSUE_EXECUTE -- requirements
Module: issue_execute

---
 rtl/issue_execute.sv | 99 +++++++++
 tb/tb_issue_execute.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/issue_execute.sv
// Dual-slot in-order issue and execute stage. Operands come from the queue head
// entries or the forward buses. Results are registered with a latency of one cycle.
module issue_execute #(
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        hold,
  input  logic [56:0] inOp0,
  input  logic [56:0] inOp1,
  input  logic [22:0] fwdIn0,
  input  logic [22:0] fwdIn1,
  input  logic [22:0] fwdIn2,
  input  logic [22:0] fwdIn3,
  output logic [1:0]  taken,
  output logic [22:0] result0,
  output logic [22:0] result1
);

  logic [3:0][22:0] w_fwd;
  logic [16:0]      w_opA0, w_opB0, w_opA1, w_opB1;
  logic             w_ready0, w_ready1;
  logic             w_issue0, w_issue1;
  logic [22:0]      r_result0, r_result1;

  // Returns {resolved, value}. Scanning from the top down lets the lowest matching bus win.
  function automatic logic [16:0] resolve(input logic        pend,
                                          input logic [5:0]  look,
                                          input logic [15:0] val,
                                          input logic [3:0][22:0] fwd);
    logic [16:0] res;
    res = {~pend, val};
    if (pend && (BYPASS != 0)) begin
      for (int i = 3; i >= 0; i--) begin
        if (fwd[i][22] && (fwd[i][21:16] == look)) res = {1'b1, fwd[i][15:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [15:0] alu(input logic [3:0]  op,
                                      input logic [15:0] a,
                                      input logic [15:0] b);
    logic [15:0] y;
    y = '0;
    case (op)
      4'd0:    y = a + b;
      4'd1:    y = a - b;
      4'd2:    y = a & b;
      4'd3:    y = a | b;
      4'd4:    y = a ^ b;
      4'd5:    y = a << b[3:0];
      4'd6:    y = a >> b[3:0];
      4'd7:    y = $unsigned($signed(a) >>> b[3:0]);
      4'd8:    y = a;
      4'd9:    y = a * b;
      4'd10:   y = {15'd0, ($signed(a) < $signed(b))};
      4'd11:   y = {15'd0, (a == b)};
      default: y = '0;
    endcase
    return y;
  endfunction

  assign w_fwd  = {fwdIn3, fwdIn2, fwdIn1, fwdIn0};

  assign w_opA0 = resolve(inOp0[1], inOp0[45:40], inOp0[33:18], w_fwd);
  assign w_opB0 = resolve(inOp0[0], inOp0[39:34], inOp0[17:2],  w_fwd);
  assign w_opA1 = resolve(inOp1[1], inOp1[45:40], inOp1[33:18], w_fwd);
  assign w_opB1 = resolve(inOp1[0], inOp1[39:34], inOp1[17:2],  w_fwd);

  assign w_ready0 = inOp0[56] & w_opA0[16] & w_opB0[16];
  assign w_ready1 = inOp1[56] & w_opA1[16] & w_opB1[16];

  // Slot1 may only follow slot0, which keeps issue strictly in order.
  assign w_issue0 = reset_n & ~flush & ~hold & w_ready0;
  assign w_issue1 = w_issue0 & w_ready1;

  assign taken = {w_issue1, w_issue0 & ~w_issue1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result0 <= '0;
      r_result1 <= '0;
    end else if (flush) begin
      r_result0 <= '0;
      r_result1 <= '0;
    end else if (!hold) begin
      r_result0 <= w_issue0 ? {1'b1, inOp0[51:46], alu(inOp0[55:52], w_opA0[15:0], w_opB0[15:0])}
                            : '0;
      r_result1 <= w_issue1 ? {1'b1, inOp1[51:46], alu(inOp1[55:52], w_opA1[15:0], w_opB1[15:0])}
                            : '0;
    end
  end

  assign result0 = r_result0;
  assign result1 = r_result1;

endmodule

// File: tb/tb_issue_execute.sv
// Directed bench for issue_execute. It checks issue, ALU ops, bypass, hold, flush
// and async reset. A second instance with BYPASS=0 is used for the no-bypass case.
module tb_issue_execute;

  logic        clk;
  logic        reset_n;
  logic        flush, hold;
  logic [56:0] inOp0, inOp1;
  logic [22:0] fwdIn0, fwdIn1, fwdIn2, fwdIn3;
  logic [1:0]  taken, taken_nb;
  logic [22:0] result0, result1, result0_nb, result1_nb;

  int n_cmp  = 0;
  int n_fail = 0;

  issue_execute #(.BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .hold(hold),
    .inOp0(inOp0), .inOp1(inOp1),
    .fwdIn0(fwdIn0), .fwdIn1(fwdIn1), .fwdIn2(fwdIn2), .fwdIn3(fwdIn3),
    .taken(taken), .result0(result0), .result1(result1)
  );

  issue_execute #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .flush(flush), .hold(hold),
    .inOp0(inOp0), .inOp1(inOp1),
    .fwdIn0(fwdIn0), .fwdIn1(fwdIn1), .fwdIn2(fwdIn2), .fwdIn3(fwdIn3),
    .taken(taken_nb), .result0(result0_nb), .result1(result1_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [56:0] mk(input logic v, input logic [3:0] op,
                                     input logic [5:0] rob, input logic [5:0] la,
                                     input logic [5:0] lb, input logic [15:0] a,
                                     input logic [15:0] b, input logic [1:0] u);
    return {v, op, rob, la, lb, a, b, u};
  endfunction

  function automatic logic [22:0] res(input logic [5:0] rob, input logic [15:0] v);
    return {1'b1, rob, v};
  endfunction

  task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pair(input string tag,
                      input logic [3:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                      input logic [5:0] rob0, input logic [15:0] e0,
                      input logic [3:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                      input logic [5:0] rob1, input logic [15:0] e1);
    inOp0 = mk(1'b1, op0, rob0, 6'd0, 6'd0, a0, b0, 2'b00);
    inOp1 = mk(1'b1, op1, rob1, 6'd0, 6'd0, a1, b1, 2'b00);
    fwdIn0 = '0; fwdIn1 = '0; fwdIn2 = '0; fwdIn3 = '0;
    #1;
    chk({tag, "_taken"}, 23'(taken), 23'd2);
    tick();
    chk({tag, "_r0"}, result0, res(rob0, e0));
    chk({tag, "_r1"}, result1, res(rob1, e1));
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; hold = 1'b0;
    inOp0 = '0; inOp1 = '0;
    fwdIn0 = '0; fwdIn1 = '0; fwdIn2 = '0; fwdIn3 = '0;
    #1;
    chk("rst_r0", result0, 23'h0);
    chk("rst_r1", result1, 23'h0);
    inOp0 = mk(1'b1, 4'd0, 6'd1, 6'd0, 6'd0, 16'h1, 16'h1, 2'b00);
    #1;
    chk("rst_taken", 23'(taken), 23'd0);
    #10;
    reset_n = 1'b1;
    tick();

    // A single ready entry with an invalid second slot.
    inOp0 = mk(1'b1, 4'd0, 6'h0A, 6'd0, 6'd0, 16'h0003, 16'h0004, 2'b00);
    inOp1 = mk(1'b0, 4'd0, 6'h0B, 6'd3, 6'd3, 16'h0, 16'h0, 2'b11);
    #1;
    chk("single_taken", 23'(taken), 23'd1);
    tick();
    chk("single_r0", result0, 23'h4A_0007);
    chk("single_r1v", 23'(result1[22]), 23'd0);

    // Slot1 operand A is supplied by fwdIn2; the no-bypass instance must stall it.
    inOp0 = mk(1'b1, 4'd2, 6'd1, 6'd0, 6'd0, 16'hF0F0, 16'h0FF0, 2'b00);
    inOp1 = mk(1'b1, 4'd1, 6'd2, 6'd5, 6'd0, 16'h1234, 16'h0001, 2'b10);
    fwdIn2 = {1'b1, 6'd5, 16'h00FF};
    #1;
    chk("byp_taken", 23'(taken), 23'd2);
    chk("nobyp_taken", 23'(taken_nb), 23'd1);
    tick();
    chk("byp_r0", result0, 23'h41_00F0);
    chk("byp_r1", result1, 23'h42_00FE);
    chk("nobyp_r0", result0_nb, 23'h41_00F0);
    chk("nobyp_r1v", 23'(result1_nb[22]), 23'd0);

    // One tag feeds both operands of slot0. The lowest valid bus wins over bus 3, and invalid bus 0 is ignored.
    inOp0 = mk(1'b1, 4'd0, 6'd3, 6'd7, 6'd7, 16'h0, 16'h0, 2'b11);
    inOp1 = mk(1'b1, 4'd9, 6'd4, 6'd7, 6'd8, 16'h0, 16'h0, 2'b11);
    fwdIn0 = {1'b0, 6'd7, 16'hAAAA};
    fwdIn1 = {1'b1, 6'd7, 16'h0010};
    fwdIn2 = {1'b1, 6'd8, 16'h0003};
    fwdIn3 = {1'b1, 6'd7, 16'hFFFF};
    #1;
    chk("multi_taken", 23'(taken), 23'd2);
    tick();
    chk("multi_r0", result0, 23'h43_0020);
    chk("multi_r1", result1, 23'h44_0030);

    // A blocked slot0 must stop a ready slot1.
    fwdIn0 = '0; fwdIn1 = '0; fwdIn2 = '0; fwdIn3 = '0;
    inOp0 = mk(1'b1, 4'd0, 6'd5, 6'd9, 6'd0, 16'h1, 16'h1, 2'b10);
    inOp1 = mk(1'b1, 4'd0, 6'd6, 6'd0, 6'd0, 16'h1, 16'h1, 2'b00);
    #1;
    chk("inorder_taken", 23'(taken), 23'd0);
    tick();
    chk("inorder_r0v", 23'(result0[22]), 23'd0);
    chk("inorder_r1v", 23'(result1[22]), 23'd0);

    pair("orxor", 4'd3, 16'h00FF, 16'h0F0F, 6'd10, 16'h0FFF,
                  4'd4, 16'h00FF, 16'h0F0F, 6'd11, 16'h0FF0);
    pair("shifts", 4'd5, 16'h0001, 16'h0013, 6'd12, 16'h0008,
                   4'd6, 16'h8000, 16'h0004, 6'd13, 16'h0800);
    pair("sarpass", 4'd7, 16'h8000, 16'h0004, 6'd14, 16'hF800,
                    4'd8, 16'hBEEF, 16'h1234, 6'd15, 16'hBEEF);
    pair("slteq", 4'd10, 16'hFFFF, 16'h0001, 6'd16, 16'h0001,
                  4'd11, 16'h5555, 16'h5555, 6'd17, 16'h0001);
    pair("subz", 4'd1, 16'h0000, 16'h0001, 6'd18, 16'hFFFF,
                 4'd13, 16'h1234, 16'h5678, 6'd19, 16'h0000);
    pair("wrap", 4'd9, 16'h0100, 16'h0100, 6'd20, 16'h0000,
                 4'd0, 16'hFFFF, 16'h0002, 6'd21, 16'h0001);
    pair("mulslt", 4'd9, 16'h0012, 16'h0003, 6'd22, 16'h0036,
                   4'd10, 16'h0001, 16'hFFFF, 6'd23, 16'h0000);

    // Hold for three cycles with ready inputs; the last results must stay presented.
    hold = 1'b1;
    inOp0 = mk(1'b1, 4'd0, 6'd30, 6'd0, 6'd0, 16'h0001, 16'h0001, 2'b00);
    inOp1 = mk(1'b1, 4'd0, 6'd31, 6'd0, 6'd0, 16'h0002, 16'h0002, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_taken", 23'(taken), 23'd0);
      tick();
      chk("hold_r0", result0, res(6'd22, 16'h0036));
      chk("hold_r1", result1, res(6'd23, 16'h0000));
    end
    hold = 1'b0;
    inOp0 = mk(1'b0, 4'd0, 6'd32, 6'd1, 6'd1, 16'h0, 16'h0, 2'b11);
    inOp1 = mk(1'b0, 4'd0, 6'd33, 6'd1, 6'd1, 16'h0, 16'h0, 2'b11);
    #1;
    chk("idle_taken", 23'(taken), 23'd0);
    tick();
    chk("idle_r0v", 23'(result0[22]), 23'd0);
    chk("idle_r1v", 23'(result1[22]), 23'd0);

    // Flush takes priority over hold.
    pair("preflush", 4'd0, 16'h0001, 16'h0002, 6'd40, 16'h0003,
                     4'd0, 16'h0003, 16'h0004, 6'd41, 16'h0007);
    hold = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_taken", 23'(taken), 23'd0);
    tick();
    chk("flush_r0v", 23'(result0[22]), 23'd0);
    chk("flush_r1v", 23'(result1[22]), 23'd0);
    hold = 1'b1;
    flush = 1'b0;
    hold = 1'b0;
    flush = 1'b1;
    #1;
    chk("flushonly_taken", 23'(taken), 23'd0);
    tick();
    flush = 1'b0;

    // Asynchronous reset asserted between edges while results are valid.
    pair("prerst", 4'd0, 16'h0010, 16'h0020, 6'd42, 16'h0030,
                   4'd2, 16'h00FF, 16'h000F, 6'd43, 16'h000F);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_r0", result0, 23'h0);
    chk("arst_r1", result1, 23'h0);
    chk("arst_taken", 23'(taken), 23'd0);
    #2;
    reset_n = 1'b1;
    inOp0 = mk(1'b1, 4'd0, 6'h0A, 6'd0, 6'd0, 16'h0003, 16'h0004, 2'b00);
    inOp1 = mk(1'b0, 4'd0, 6'd0, 6'd0, 6'd0, 16'h0, 16'h0, 2'b00);
    #1;
    chk("resume_taken", 23'(taken), 23'd1);
    tick();
    chk("resume_r0", result0, 23'h4A_0007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
